// File: rtl/perf_pkg.sv
// Frame-dumper types/constants; PERF_DUMP_CHECKSUM_EN adds one checksum byte to FRAME_LEN.
// Pure declarations: no latency, no flow control.
package perf_pkg;

  typedef enum logic [1:0] {IDLE, SEND, DONE} dump_state_t;

  // Frame order of the counters after the header byte.
  typedef enum logic [2:0] {
    CTR_CYCLES, CTR_INSTR, CTR_ARITH, CTR_MEMORY, CTR_STALL
  } ctr_idx_t;

  localparam int         NUM_COUNTERS      = int'(CTR_STALL) + 1;
  localparam logic [7:0] DEFAULT_HEADER    = 8'hA5;
  localparam int         DEFAULT_COUNTER_W = 32;
  localparam int         FRAME_LEN_BASE    = 1;

`ifdef PERF_DUMP_CHECKSUM_EN
  localparam int CKSUM_BYTES = 1;
`else
  localparam int CKSUM_BYTES = 0;
`endif

  function automatic int frame_len(input int counter_w);
    return FRAME_LEN_BASE + NUM_COUNTERS * (counter_w / 8) + CKSUM_BYTES;
  endfunction

  localparam int FRAME_LEN = frame_len(DEFAULT_COUNTER_W);

endpackage

// File: rtl/perf_checksum_acc.sv
// XOR byte accumulator with clear/enable, only built with PERF_DUMP_CHECKSUM_EN.
// Result visible the cycle after each enabled byte; no flow control of its own.
`ifdef PERF_DUMP_CHECKSUM_EN
module perf_checksum_acc (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] acc
);

  logic [7:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q ^ din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule
`endif

// File: rtl/perf_counter_dumper.sv
// Snapshots five counters on a finish rise and streams header + little-endian bytes (+ checksum under PERF_DUMP_CHECKSUM_EN).
// Header valid one cycle after the rise; each byte held until out_valid && out_ready, one byte per cycle max.
module perf_counter_dumper
  import perf_pkg::*;
#(
  parameter int         COUNTER_W   = DEFAULT_COUNTER_W,
  parameter logic [7:0] HEADER_BYTE = DEFAULT_HEADER
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 finish,
  input  logic [COUNTER_W-1:0] cycles,
  input  logic [COUNTER_W-1:0] instr_count,
  input  logic [COUNTER_W-1:0] aritmetric_count,
  input  logic [COUNTER_W-1:0] memory_count,
  input  logic [COUNTER_W-1:0] stall_count,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int               FLEN     = frame_len(COUNTER_W);
  localparam int               IDX_W    = $clog2(FLEN);
  localparam int               SNAP_W   = NUM_COUNTERS * COUNTER_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FLEN - 1);

  dump_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SNAP_W-1:0] snap_q, snap_d;
  logic             finish_q, finish_d;

  logic             trigger;
  logic             xfer;
  logic [IDX_W-1:0] pay_idx;
  logic [7:0]       payload_byte;
  logic [7:0]       frame_byte;

  assign trigger = (state_q == IDLE) && finish && !finish_q;
  assign xfer    = (state_q == SEND) && out_ready;

  // Byte index 1 maps to bit 0 of the snapshot; cycles sits in the low word.
  assign pay_idx      = idx_q - IDX_W'(1);
  assign payload_byte = 8'(snap_q >> {pay_idx, 3'b000});

`ifdef PERF_DUMP_CHECKSUM_EN
  logic [7:0] cksum;
  logic       acc_en;

  assign acc_en = xfer && (idx_q != '0) && (idx_q != LAST_IDX);

  perf_checksum_acc u_cksum (
    .clk (clk),
    .rst (rst),
    .clr (trigger),
    .en  (acc_en),
    .din (payload_byte),
    .acc (cksum)
  );

  assign frame_byte = (idx_q == '0)      ? HEADER_BYTE :
                      (idx_q == LAST_IDX) ? cksum       : payload_byte;
`else
  assign frame_byte = (idx_q == '0) ? HEADER_BYTE : payload_byte;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    finish_d  = finish;
    out_valid = 1'b0;
    out_data  = '0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = SEND;
          idx_d   = '0;
          snap_d  = {stall_count, memory_count, aritmetric_count, instr_count, cycles};
        end
      end
      SEND: begin
        out_valid = 1'b1;
        out_data  = frame_byte;
        busy      = 1'b1;
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        done = 1'b1;
        // A new frame needs finish to go low first.
        if (!finish) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      snap_q   <= '0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      snap_q   <= snap_d;
      finish_q <= finish_d;
    end
  end

endmodule

// File: tb/tb_perf_counter_dumper.sv
// Bench for perf_counter_dumper: directed frame table plus random counters against a byte-list model.
// Follows PERF_DUMP_CHECKSUM_EN to decide whether a checksum byte is expected.
module tb_perf_counter_dumper;

`ifdef PERF_DUMP_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        finish;
  logic [31:0] cycles, instr_count, aritmetric_count, memory_count, stall_count;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  perf_counter_dumper dut (
    .clk              (clk),
    .rst              (rst),
    .finish           (finish),
    .cycles           (cycles),
    .instr_count      (instr_count),
    .aritmetric_count (aritmetric_count),
    .memory_count     (memory_count),
    .stall_count      (stall_count),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .busy             (busy),
    .done             (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference frame: header, each counter least-significant byte first, optional XOR of payload.
  task automatic build_model(input logic [31:0] c[5]);
    logic [7:0] ck;
    logic [7:0] b;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    ck = 8'h00;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) begin
        b = 8'((c[k] / (32'd1 << (8 * i))) % 256);
        exp_q.push_back(b);
        ck = ck ^ b;
      end
    end
    if (CK_EN) exp_q.push_back(ck);
  endtask

  // mode 0: always ready, 1: random ready, 2: 3-cycle stall on byte 2, 3: finish toggles mid-frame.
  task automatic collect(input int mode, input int abort_at, output bit aborted);
    int   n = 0;
    int   cyc = 0;
    int   stalls = 0;
    bit   was_stall = 1'b0;
    bit   xfer;
    aborted = 1'b0;
    while (n < exp_q.size() && cyc < 400) begin
      if (n == abort_at) begin
        out_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("abort_vld", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_dat", out_data, 0);
        finish = 1'b0;
        aborted = 1'b1;
        return;
      end
      if (was_stall) begin
        check($sformatf("hold_vld%0d", n), out_valid, 1);
        check($sformatf("hold_dat%0d", n), out_data, exp_q[n]);
      end
      case (mode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: out_ready = !(n == 2 && stalls < 3);
        default: out_ready = 1'b1;
      endcase
      if (mode == 2 && n == 2 && !out_ready) stalls++;
      if (mode == 3) finish = !(n >= 5 && n < 8);
      xfer      = out_valid && out_ready;
      was_stall = out_valid && !out_ready;
      if (xfer) check($sformatf("byte%0d", n), out_data, exp_q[n]);
      tick();
      cyc++;
      if (xfer) n++;
    end
    out_ready = 1'b0;
    if (n != exp_q.size()) begin
      errors++;
      $display("FAIL frame_timeout actual=%0d bytes required=%0d bytes", n, exp_q.size());
    end
  endtask

  task automatic run_frame(input logic [31:0] c[5], input int mode, input int abort_at,
                           input bit rnd_scramble);
    bit aborted;
    cycles = c[0]; instr_count = c[1]; aritmetric_count = c[2];
    memory_count = c[3]; stall_count = c[4];
    finish = 1'b1;
    tick();
    check("lat1_vld", out_valid, 1);
    check("lat1_busy", busy, 1);
    cycles           = rnd_scramble ? $urandom : 32'h0;
    instr_count      = rnd_scramble ? $urandom : 32'h0;
    aritmetric_count = rnd_scramble ? $urandom : 32'h0;
    memory_count     = rnd_scramble ? $urandom : 32'h0;
    stall_count      = rnd_scramble ? $urandom : 32'h0;
    collect(mode, abort_at, aborted);
    if (aborted) begin
      tick();
      tick();
      rst = 1'b1;
      repeat (3) tick();
      check("post_rst_vld", out_valid, 0);
      check("post_rst_busy", busy, 0);
      check("post_rst_done", done, 0);
      return;
    end
    check("done_set", done, 1);
    check("busy_clr", busy, 0);
    check("vld_clr", out_valid, 0);
    repeat (3) tick();
    check("done_hold", done, 1);
    check("no_retrig", out_valid, 0);
    finish = 1'b0;
    tick();
    check("done_clr", done, 0);
    check("idle_busy", busy, 0);
    tick();
  endtask

  typedef struct {
    logic [31:0]    c [5];
    logic [167:0]   frame;
    logic [7:0]     ck;
    int             mode;
    int             abort_at;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [31:0] rc[5];

    tbl[0].c = '{32'h11223344, 32'd5, 32'd3, 32'd1, 32'd1};
    tbl[0].frame = 168'hA5_44332211_05000000_03000000_01000000_01000000;
    tbl[0].ck = 8'h42; tbl[0].mode = 0; tbl[0].abort_at = -1;
    tbl[1] = tbl[0]; tbl[1].mode = 2;
    tbl[2].c = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[2].frame = {8'hA5, 160'h0};
    tbl[2].ck = 8'h00; tbl[2].mode = 3; tbl[2].abort_at = -1;
    tbl[3].c = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[3].frame = {8'hA5, {160{1'b1}}};
    tbl[3].ck = 8'h00; tbl[3].mode = 1; tbl[3].abort_at = -1;
    tbl[4] = tbl[0]; tbl[4].abort_at = 10;
    tbl[5].c = '{32'h01020304, 32'hA0B0C0D0, 32'h00000080, 32'h7F000000, 32'hDEADBEEF};
    tbl[5].frame = 168'hA5_04030201_D0C0B0A0_80000000_0000007F_EFBEADDE;
    tbl[5].ck = 8'hD9; tbl[5].mode = 1; tbl[5].abort_at = -1;

    rst = 1'b0; finish = 1'b0; out_ready = 1'b0;
    cycles = '0; instr_count = '0; aritmetric_count = '0; memory_count = '0; stall_count = '0;
    #3;
    check("rst_vld", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dat", out_data, 0);
    tick();
    tick();
    rst = 1'b1;
    repeat (3) tick();
    check("idle_vld", out_valid, 0);

    // Asynchronous reset asserted between clock edges while idle.
    #2 rst = 1'b0;
    #1;
    check("midle_rst_vld", out_valid, 0);
    check("midle_rst_busy", busy, 0);
    check("midle_rst_done", done, 0);
    check("midle_rst_dat", out_data, 0);
    tick();
    rst = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      exp_q.delete();
      for (int j = 0; j < 21; j++) exp_q.push_back(tbl[i].frame[8 * (20 - j) +: 8]);
      if (CK_EN) exp_q.push_back(tbl[i].ck);
      run_frame(tbl[i].c, tbl[i].mode, tbl[i].abort_at, 1'b0);
    end

    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 5; k++) rc[k] = $urandom;
      build_model(rc);
      run_frame(rc, 1, -1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
